// File: rtl/sd_pkg.sv
// Shared arithmetic helpers and constants for the sigma-delta modulator.
package sd_pkg;

  localparam int unsigned SD_CW = 64;
  localparam logic signed [SD_CW-1:0] SD_ONE = SD_CW'(1);

  localparam int unsigned SD_ORDER_MIN = 1;
  localparam int unsigned SD_ORDER_MAX = 2;

  localparam logic [15:0] LFSR_TAPS = 16'hB400;
  localparam logic [15:0] LFSR_SEED = 16'hACE1;

  function automatic bit order_legal(input int unsigned o);
    return (o >= SD_ORDER_MIN) && (o <= SD_ORDER_MAX);
  endfunction

  function automatic logic signed [SD_CW-1:0] sd_max(input int unsigned w);
    return (SD_ONE <<< (w - 1)) - SD_ONE;
  endfunction

  function automatic logic signed [SD_CW-1:0] sd_min(input int unsigned w);
    return -(SD_ONE <<< (w - 1));
  endfunction

  // Add and saturate into a signed w-bit range.
  function automatic logic signed [SD_CW-1:0] sat_add(input logic signed [SD_CW-1:0] a,
                                                      input logic signed [SD_CW-1:0] b,
                                                      input int unsigned w);
    logic signed [SD_CW-1:0] s;
    s = a + b;
    if (s > sd_max(w)) return sd_max(w);
    if (s < sd_min(w)) return sd_min(w);
    return s;
  endfunction

  function automatic logic sat_hit(input logic signed [SD_CW-1:0] a,
                                   input logic signed [SD_CW-1:0] b,
                                   input int unsigned w);
    logic signed [SD_CW-1:0] s;
    s = a + b;
    return (s > sd_max(w)) || (s < sd_min(w));
  endfunction

  // Round-half-up of q / 2^sh.
  function automatic logic signed [SD_CW-1:0] round_shr(input logic signed [SD_CW-1:0] q,
                                                        input int unsigned sh);
    return (q + (SD_ONE <<< (sh - 1))) >>> sh;
  endfunction

  function automatic logic signed [SD_CW-1:0] clamp_round(input logic signed [SD_CW-1:0] q,
                                                          input int unsigned sh,
                                                          input int unsigned ow);
    logic signed [SD_CW-1:0] r;
    r = round_shr(q, sh);
    if (r > sd_max(ow)) return sd_max(ow);
    if (r < sd_min(ow)) return sd_min(ow);
    return r;
  endfunction

  function automatic logic clamp_hit(input logic signed [SD_CW-1:0] q,
                                     input int unsigned sh,
                                     input int unsigned ow);
    logic signed [SD_CW-1:0] r;
    r = round_shr(q, sh);
    return (r > sd_max(ow)) || (r < sd_min(ow));
  endfunction

endpackage

// File: rtl/sd_lfsr16.sv
// 16-bit Galois LFSR dither source; only present when SIGMA_DELTA_DITHER_EN is defined.
`ifdef SIGMA_DELTA_DITHER_EN
module sd_lfsr16
  import sd_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  output logic [15:0] state
);

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= LFSR_SEED;
    end else if (en) begin
      state <= (state >> 1) ^ (state[0] ? LFSR_TAPS : 16'h0000);
    end
  end

endmodule
`endif

// File: rtl/sigma_delta_mod.sv
// 1st/2nd-order sigma-delta modulator with framed sample hold and sticky flags.
// Define SIGMA_DELTA_DITHER_EN to add LFSR dither ahead of the quantizer.
module sigma_delta_mod
  import sd_pkg::*;
#(
  parameter int unsigned IN_WIDTH  = 16,
  parameter int unsigned OUT_WIDTH = 1,
  parameter int unsigned ORDER     = 1,
  parameter int unsigned OSR       = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [IN_WIDTH-1:0]  in,
  output logic [OUT_WIDTH-1:0] sd_out,
  output logic                 sd_valid,
  output logic                 underrun,
  output logic                 overflow,
  input  logic                 clr_flags
);

  localparam int unsigned INT_W = IN_WIDTH + 3;
  localparam int unsigned Q     = IN_WIDTH - OUT_WIDTH;
  localparam int unsigned CNT_W = (OSR > 1) ? $clog2(OSR) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(OSR - 1);

  if (!order_legal(ORDER)) begin : g_bad_order
    $error("sigma_delta_mod: ORDER must be 1 or 2");
  end

  logic [CNT_W-1:0]          cnt;
  logic signed [IN_WIDTH-1:0] pending;
  logic signed [IN_WIDTH-1:0] active;
  logic signed [INT_W-1:0]    i1, i2, i1_n, i2_n;
  logic signed [SD_CW-1:0]    x_w, v_w, q_w;
  logic [OUT_WIDTH-1:0]       out_n;
  logic                       sat_ev;
  logic                       boundary;

`ifdef SIGMA_DELTA_DITHER_EN
  localparam int unsigned DSH = (OUT_WIDTH == 1) ? IN_WIDTH - 3 : Q - 2;
  logic [15:0] lfsr_state;

  sd_lfsr16 u_lfsr (
    .clk   (clk),
    .rst   (rst),
    .en    (en),
    .state (lfsr_state)
  );
`endif

  assign boundary = en && (cnt == LAST);

  // Loop update: integrators, feedback and quantizer.
  always_comb begin
    x_w = SD_CW'(active);
    if (OUT_WIDTH == 1) begin
      v_w = sd_out[0] ? (SD_ONE <<< (IN_WIDTH - 1)) : -(SD_ONE <<< (IN_WIDTH - 1));
    end else begin
      v_w = SD_CW'($signed(sd_out)) <<< Q;
    end
    i1_n   = INT_W'(sat_add(SD_CW'(i1), x_w - v_w, INT_W));
    sat_ev = sat_hit(SD_CW'(i1), x_w - v_w, INT_W);
    i2_n   = i2;
    q_w    = SD_CW'(i1_n);
    if (ORDER == 2) begin
      i2_n   = INT_W'(sat_add(SD_CW'(i2), SD_CW'(i1_n) - v_w, INT_W));
      sat_ev = sat_ev | sat_hit(SD_CW'(i2), SD_CW'(i1_n) - v_w, INT_W);
      q_w    = SD_CW'(i2_n);
    end
`ifdef SIGMA_DELTA_DITHER_EN
    q_w = q_w + (SD_CW'($signed(lfsr_state[1:0])) <<< DSH);
`endif
    if (OUT_WIDTH == 1) begin
      out_n = OUT_WIDTH'(q_w >= 0);
    end else begin
      out_n  = OUT_WIDTH'(clamp_round(q_w, Q, OUT_WIDTH));
      sat_ev = sat_ev | clamp_hit(q_w, Q, OUT_WIDTH);
    end
  end

  // in_ready doubles as the pending-empty flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt      <= '0;
      pending  <= '0;
      active   <= '0;
      in_ready <= 1'b1;
      i1       <= '0;
      i2       <= '0;
      sd_out   <= '0;
      sd_valid <= 1'b0;
      underrun <= 1'b0;
      overflow <= 1'b0;
    end else begin
      sd_valid <= en;
      if (in_valid && in_ready) begin
        pending  <= in;
        in_ready <= 1'b0;
      end
      if (en) begin
        i1     <= i1_n;
        i2     <= i2_n;
        sd_out <= out_n;
        cnt    <= (cnt == LAST) ? '0 : cnt + CNT_W'(1);
      end
      if (boundary && !in_ready) begin
        active   <= pending;
        in_ready <= 1'b1;
      end
      underrun <= (boundary && in_ready) || (underrun && !clr_flags);
      overflow <= (en && sat_ev) || (overflow && !clr_flags);
    end
  end

endmodule

// File: tb/tb_sigma_delta_mod.sv
// Directed bench: 1st-order 1-bit and 2nd-order 4-bit instances share one stimulus stream.
module tb_sigma_delta_mod;

  logic        clk;
  logic        rst;
  logic        en;
  logic        in_valid;
  logic        clr_flags;
  logic [15:0] din;

  logic       a_ready, a_valid, a_ur, a_ov;
  logic [0:0] a_out;
  logic       b_ready, b_valid, b_ur, b_ov;
  logic [3:0] b_out;

  int total = 0;
  int bad   = 0;

  sigma_delta_mod #(.IN_WIDTH(16), .OUT_WIDTH(1), .ORDER(1), .OSR(4)) u_a (
    .clk(clk), .rst(rst), .en(en), .in_valid(in_valid), .in_ready(a_ready), .in(din),
    .sd_out(a_out), .sd_valid(a_valid), .underrun(a_ur), .overflow(a_ov), .clr_flags(clr_flags)
  );

  sigma_delta_mod #(.IN_WIDTH(16), .OUT_WIDTH(4), .ORDER(2), .OSR(4)) u_b (
    .clk(clk), .rst(rst), .en(en), .in_valid(in_valid), .in_ready(b_ready), .in(din),
    .sd_out(b_out), .sd_valid(b_valid), .underrun(b_ur), .overflow(b_ov), .clr_flags(clr_flags)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
    total++;
    assert (obs === want) else begin
      bad++;
      $error("FAIL %s: got %0h want %0h", tag, obs, want);
    end
  endtask

  task automatic chk_rng(input string tag, input int obs, input int lo, input int hi);
    total++;
    assert (obs >= lo && obs <= hi) else begin
      bad++;
      $error("FAIL %s: got %0d want %0d..%0d", tag, obs, lo, hi);
    end
  endtask

  task automatic tick(input logic e, input logic v, input logic [15:0] d, input logic c);
    en = e; in_valid = v; din = d; clr_flags = c;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick(1'b0, 1'b0, 16'h0000, 1'b0);
    tick(1'b0, 1'b0, 16'h0000, 1'b0);
    rst = 1'b0;
  endtask

  bit   exp_a [16] = '{1,1,0,1, 0,1,1,1, 0,1,1,1, 0,0,0,1};
  logic [3:0] exp_bp [8] = '{4'h0,4'h0,4'h0,4'h0, 4'h2,4'h1,4'h1,4'h2};
  logic [3:0] exp_bn [8] = '{4'h0,4'h0,4'h0,4'h0, 4'hF,4'hE,4'hE,4'hF};
  int ones;

  initial begin
    rst = 1'b1; en = 1'b0; in_valid = 1'b0; clr_flags = 1'b0; din = '0;
    do_reset();
    chk("rst_a_out", 32'(a_out), 0);
    chk("rst_a_valid", 32'(a_valid), 0);
    chk("rst_a_ur", 32'(a_ur), 0);
    chk("rst_a_ov", 32'(a_ov), 0);
    chk("rst_a_ready", 32'(a_ready), 1);
    chk("rst_b_out", 32'(b_out), 0);

    // Frame hold, underrun with held active value, late-accepted sample.
    for (int s = 1; s <= 16; s++) begin
      tick(1'b1, (s == 1 || s == 8), (s == 8) ? 16'hC000 : 16'h4000, 1'b0);
      chk($sformatf("hold_out_s%0d", s), 32'(a_out), 32'(exp_a[s-1]));
      if (s == 1) begin
        chk("hold_valid_s1", 32'(a_valid), 1);
        chk("hold_ready_s1", 32'(a_ready), 0);
      end
      if (s == 3) chk("hold_ready_s3", 32'(a_ready), 0);
      if (s == 4) begin
        chk("hold_ready_s4", 32'(a_ready), 1);
        chk("hold_ur_s4", 32'(a_ur), 0);
      end
      if (s == 7) chk("hold_ur_s7", 32'(a_ur), 0);
      if (s == 8) begin
        chk("hold_ur_s8", 32'(a_ur), 1);
        chk("hold_ready_s8", 32'(a_ready), 0);
      end
      if (s == 11) chk("hold_ready_s11", 32'(a_ready), 0);
      if (s == 12) chk("hold_ready_s12", 32'(a_ready), 1);
    end
    tick(1'b0, 1'b0, 16'h0000, 1'b0);
    chk("idle_valid", 32'(a_valid), 0);
    chk("idle_out_held", 32'(a_out), 1);
    chk("idle_ur", 32'(a_ur), 1);
    tick(1'b0, 1'b0, 16'h0000, 1'b1);
    chk("clr_ur", 32'(a_ur), 0);
    for (int s = 0; s < 3; s++) tick(1'b1, 1'b0, 16'h0000, 1'b0);
    tick(1'b1, 1'b0, 16'h0000, 1'b1);
    chk("clr_vs_set_ur", 32'(a_ur), 1);
    tick(1'b0, 1'b0, 16'h0000, 1'b1);
    chk("clr2_ur", 32'(a_ur), 0);

    // Zero input: 1,1 then strict alternation.
    do_reset();
    ones = 0;
    for (int s = 1; s <= 66; s++) begin
      tick(1'b1, 1'b1, 16'h0000, 1'b0);
      if (s == 3) chk("zero_s3", 32'(a_out), 0);
      if (s == 4) chk("zero_s4", 32'(a_out), 1);
      if (s >= 3) ones += int'(a_out);
    end
    chk("zero_ones", 32'(ones), 32);

    do_reset();
    for (int s = 0; s < 8; s++) tick(1'b1, 1'b1, 16'h4000, 1'b0);
    ones = 0;
    for (int s = 0; s < 64; s++) begin
      tick(1'b1, 1'b1, 16'h4000, 1'b0);
      ones += int'(a_out);
    end
    chk_rng("pos_half_ones", ones, 47, 49);

    do_reset();
    for (int s = 0; s < 8; s++) tick(1'b1, 1'b1, 16'hC000, 1'b0);
    ones = 0;
    for (int s = 0; s < 64; s++) begin
      tick(1'b1, 1'b1, 16'hC000, 1'b0);
      ones += int'(a_out);
    end
    chk_rng("neg_half_ones", ones, 15, 17);

    // 2nd-order multi-bit rounding, half-up on both signs.
    do_reset();
    for (int s = 0; s < 8; s++) begin
      tick(1'b1, 1'b1, 16'h1800, 1'b0);
      chk($sformatf("rnd_pos_s%0d", s + 1), 32'(b_out), 32'(exp_bp[s]));
    end
    chk("rnd_pos_ov", 32'(b_ov), 0);
    do_reset();
    for (int s = 0; s < 8; s++) begin
      tick(1'b1, 1'b1, 16'hE800, 1'b0);
      chk($sformatf("rnd_neg_s%0d", s + 1), 32'(b_out), 32'(exp_bn[s]));
    end
    chk("rnd_neg_ov", 32'(b_ov), 0);

    // Full-scale input saturates the 2nd-order loop and clamps the output.
    do_reset();
    for (int s = 1; s <= 500; s++) begin
      tick(1'b1, 1'b1, 16'h7FFF, 1'b0);
      if (s > 300) chk($sformatf("sat_out_s%0d", s), 32'(b_out), 7);
    end
    chk("sat_b_ov", 32'(b_ov), 1);
    chk("sat_b_ur", 32'(b_ur), 0);
    chk("sat_a_ov", 32'(a_ov), 0);

    tick(1'b1, 1'b1, 16'h7FFF, 1'b0);
    tick(1'b1, 1'b1, 16'h7FFF, 1'b0);
    rst = 1'b1;
    tick(1'b1, 1'b1, 16'h7FFF, 1'b0);
    chk("midrst_b_out", 32'(b_out), 0);
    chk("midrst_b_valid", 32'(b_valid), 0);
    chk("midrst_b_ov", 32'(b_ov), 0);
    chk("midrst_b_ur", 32'(b_ur), 0);
    chk("midrst_b_ready", 32'(b_ready), 1);
    chk("midrst_a_out", 32'(a_out), 0);
    rst = 1'b0;
    tick(1'b0, 1'b0, 16'h0000, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
